plantard_mm_pipe: RTL and testbench
===================================

# plantard_mm_pipe

Parametrised, fully pipelined Plantard modular multiplier. It computes c = a·b·(−2^(−2L)) mod Q for two variable operands, with L = DATA_W+1. It accepts one operand pair per cycle over a valid/ready handshake, stalls under backpressure, and carries a sideband tag so NTT butterfly control can match results to coefficient indices. It supersedes the fixed-constant, handshake-free multiplier in the NTT datapath.

## Interface
- DATA_W, 14, operand and result width; Q < 2^DATA_W.
- Q, 12289, modulus; must be odd.
- QINV, 150982657, Q^(−1) mod 2^(2L); 2L bits wide.
- TAG_W, 8, sideband tag width; must be ≥1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts this cycle.
- a_in  input  DATA_W  operand a, must be < Q.
- b_in  input  DATA_W  operand b, must be < Q.
- tag_in  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts.
- c_out  output  DATA_W  result, always in [0, Q−1].
- tag_out  output  TAG_W  tag of the current result.

## Operation
- Fire-in = in_valid & in_ready. Fire-out = out_valid & out_ready.
- Four register stages, S1–S4. Each stage has a valid bit plus its data and tag registers.
- S1: p = a_in·b_in, 2·DATA_W bits, unsigned.
- S2: u = (p·QINV mod 2^(2L)) >> L, L bits. Only the low 2L bits of the product are kept.
- S3: m = (u+1)·Q. Width is L+DATA_W+1 bits, so u = 2^L−1 does not overflow.
- S4: r = m >> L, DATA_W+1 bits. c_out = (r == Q) ? 0 : r[DATA_W−1:0].
- Correctness requires a·b < Q·2^L. This is guaranteed by a, b < Q. Inputs ≥ Q are out of contract and give unspecified results, but the handshake must still behave correctly.
- Stall: stall = S4.valid & ~out_ready.
  - When stall is high, every stage holds its data and valid bits.
  - When stall is low, all stages advance together. S1 loads {in_valid, operands, tag}.
- in_ready = ~stall. This is combinational from out_ready and S4.valid. There is no combinational path from in_valid to in_ready.
- Bubbles are not compressed. An empty stage advances like a full one. Ordering is strict FIFO.
- tag_out and c_out come from S4 and are held stable while out_valid & ~out_ready.
- The block has no mode or state machine beyond the pipeline valid chain. Occupancy ranges from 0 to 4.

## Timing
- Reset (rst=0) clears all valid bits immediately and asynchronously. Data and tag registers reset to 0.
- Output values during reset: out_valid=0, c_out=0, tag_out=0. in_ready=1, since stall is 0.
- Reset asserted mid-stream discards all in-flight items. Nothing stale appears after release.
- Latency: an item that fires in at edge k presents out_valid=1 after edge k+3 (4 register stages), provided there is no stall.
- Throughput: 1 result per cycle with in_valid=1 and out_ready=1 continuously.
- Simultaneous in-fire and out-fire in the same cycle is legal and loses nothing.
- out_ready may be low while out_valid=0. This does not stall the pipeline.
- Stall with S4 full and out_ready low: in_ready drops in the same cycle. No item is accepted or dropped, and the pipeline holds all 4 items.
- Releasing out_ready resumes with zero dead cycles.

## Test plan
- Reset: stream 3 items, then pull rst low for 1 cycle mid-flight. Required: out_valid=0, c_out=0, tag_out=0, in_ready=1 during reset; no output for the lost items after release; the next item has latency 4.
- Zero: a=0, b=5, tag=0x2A, out_ready=1. Required: out_valid after 4 edges, c_out=0, tag_out=0x2A, out_valid high for exactly 1 cycle.
- Unit: a=1, b=1. Required: (c_out·2738 + 1) mod 12289 = 0, where 2738 = 2^30 mod 12289, and c_out < 12289.
- Boundary: a=b=12288, then a=12288, b=1. Required: each result satisfies (c·2738 + a·b) mod 12289 = 0 and c ≠ 12289.
- Stream: 1000 random pairs below Q, in_valid=1 and out_ready=1 throughout. Required: 1000 results in 1003 cycles, in order, tags match, every result satisfies the relation above.
- Backpressure: random in_valid and out_ready at 50% each, plus one 6-cycle stretch with out_ready=0. Required: no loss or duplication, FIFO order, in_ready=0 exactly while S4 is full and out_ready=0, c_out and tag_out stable during stalls.

Source files
------------

// File: rtl/plantard_mm_pipe_if.sv
// Operand/result stream bundle for the Plantard modular multiplier.
// The slave modport is the multiplier side; the master modport is the producer/consumer side.
interface plantard_mm_pipe_if #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned TAG_W  = 8
);
  // Input side: operand pair plus sideband tag
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [TAG_W-1:0]  tag_in;

  // Output side: reduced product plus the tag that travelled with it
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] c_out;
  logic [TAG_W-1:0]  tag_out;

  modport slave (
    input  in_valid,
    input  a_in,
    input  b_in,
    input  tag_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output c_out,
    output tag_out
  );

  modport master (
    output in_valid,
    output a_in,
    output b_in,
    output tag_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  c_out,
    input  tag_out
  );
endinterface

// File: rtl/plantard_mm_pipe.sv
// Four-stage pipelined Plantard modular multiplier: c = a*b*(-2^(-2L)) mod Q, L = DATA_W+1.
// One operand pair per cycle over valid/ready; the whole pipeline freezes when the
// output stage is occupied and the consumer is not ready. A sideband tag rides along.
module plantard_mm_pipe #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned Q      = 12289,
  parameter logic [63:0] QINV   = 64'd150982657,
  parameter int unsigned TAG_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  plantard_mm_pipe_if.slave   bus
);

  localparam int unsigned L   = DATA_W + 1;
  localparam int unsigned PW  = 2 * DATA_W;
  localparam int unsigned W2L = 2 * L;
  localparam int unsigned MW  = L + DATA_W + 1;

  localparam logic [W2L-1:0]  QINV_L = QINV[W2L-1:0];
  localparam logic [DATA_W:0] Q_R    = (DATA_W+1)'(Q);

  // u = (p * Q^-1 mod 2^(2L)) >> L; only the low 2L bits of the product matter
  function automatic logic [L-1:0] plantard_u(input logic [PW-1:0] p);
    logic [W2L-1:0] lo;
    lo = W2L'(p) * QINV_L;
    return lo[W2L-1:L];
  endfunction

  // m = (u + 1) * Q; the extra headroom bit keeps u = 2^L-1 from wrapping
  function automatic logic [MW-1:0] plantard_m(input logic [L-1:0] u);
    return (MW'(u) + MW'(1)) * MW'(Q);
  endfunction

  // r = m >> L lands in [0, Q]; fold the single out-of-range value Q back to 0
  function automatic logic [DATA_W-1:0] plantard_fix(input logic [MW-1:0] m);
    logic [DATA_W:0] r;
    r = m[MW-1:L];
    return (r == Q_R) ? '0 : r[DATA_W-1:0];
  endfunction

  // Pipeline control
  logic stall;
  logic adv;

  // Valid chain
  logic vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;

  // Datapath registers and their next-state values
  logic [PW-1:0]     p_p1_q, p_p1_d;
  logic [L-1:0]      u_p2_q, u_p2_d;
  logic [MW-1:0]     m_p3_q, m_p3_d;
  logic [DATA_W-1:0] c_p4_q, c_p4_d;

  // Tag shadow of each stage
  logic [TAG_W-1:0]  tag_p1_q, tag_p2_q, tag_p3_q, tag_p4_q;

  // The only thing that can block progress is a full output stage facing a busy consumer
  assign stall = vld_p4_q & ~bus.out_ready;
  assign adv   = ~stall;

  // S1: full-width unsigned product of the two operands
  assign p_p1_d = PW'(bus.a_in) * PW'(bus.b_in);

  // S2: Plantard quotient estimate
  assign u_p2_d = plantard_u(p_p1_q);

  // S3: scale the incremented estimate back by the modulus
  assign m_p3_d = plantard_m(u_p2_q);

  // S4: take the high half and canonicalise into [0, Q-1]
  assign c_p4_d = plantard_fix(m_p3_q);

  // Valid bits shift together whenever the pipeline is not frozen; bubbles advance too
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      vld_p4_q <= 1'b0;
    end else if (adv) begin
      vld_p1_q <= bus.in_valid;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
      vld_p4_q <= vld_p3_q;
    end
  end

  // Data and tag registers follow the same enable so results and tags never drift apart
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_p1_q   <= '0;
      u_p2_q   <= '0;
      m_p3_q   <= '0;
      c_p4_q   <= '0;
      tag_p1_q <= '0;
      tag_p2_q <= '0;
      tag_p3_q <= '0;
      tag_p4_q <= '0;
    end else if (adv) begin
      p_p1_q   <= p_p1_d;
      u_p2_q   <= u_p2_d;
      m_p3_q   <= m_p3_d;
      c_p4_q   <= c_p4_d;
      tag_p1_q <= bus.tag_in;
      tag_p2_q <= tag_p1_q;
      tag_p3_q <= tag_p2_q;
      tag_p4_q <= tag_p3_q;
    end
  end

  // in_ready depends only on S4 occupancy and out_ready, never on in_valid
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_p4_q;
  assign bus.c_out     = c_p4_q;
  assign bus.tag_out   = tag_p4_q;

endmodule

// File: tb/tb_plantard_mm_pipe.sv
// Bench for plantard_mm_pipe: directed vector table, reset/latency sequences,
// a full-rate stream and a randomised backpressure run against a scoreboard.
module tb_plantard_mm_pipe;

  localparam int DATA_W = 14;
  localparam int TAG_W  = 8;
  localparam longint Q  = 12289;
  localparam longint R30 = 2738;   // 2^30 mod Q

  logic clk;
  logic rst;

  plantard_mm_pipe_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  plantard_mm_pipe #(
    .DATA_W(DATA_W),
    .Q(12289),
    .QINV(64'd150982657),
    .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  longint inv30 = 0;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] exp;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] exp;
  } sb_t;

  sb_t sb[$];
  int n_in = 0;
  int n_out = 0;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_c;
  logic [TAG_W-1:0]  prev_tag;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", nm, got, exp);
    end
  endtask

  // c = -a*b * (2^30)^-1 mod Q, computed with plain modular arithmetic
  function automatic logic [DATA_W-1:0] model_c(input longint a, input longint b);
    longint t;
    t = (a * b) % Q;
    t = (t * inv30) % Q;
    return DATA_W'((Q - t) % Q);
  endfunction

  // Scoreboard and protocol monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (prev_stall) begin
        chk("stall_hold_valid", bus.out_valid, 1);
        chk("stall_hold_c", bus.c_out, prev_c);
        chk("stall_hold_tag", bus.tag_out, prev_tag);
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back('{a: bus.a_in, b: bus.b_in, tag: bus.tag_in,
                       exp: model_c(longint'(bus.a_in), longint'(bus.b_in))});
        n_in++;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          sb_t e;
          e = sb.pop_front();
          chk("sb_c", bus.c_out, e.exp);
          chk("sb_tag", bus.tag_out, e.tag);
          chk("sb_rel", (longint'(bus.c_out) * R30 + longint'(e.a) * longint'(e.b)) % Q, 0);
        end
        chk("sb_range", longint'(bus.c_out) < Q, 1);
        n_out++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_c     = bus.c_out;
      prev_tag   = bus.tag_out;
    end
  end

  // Single item into an empty pipeline; returns result and edges from fire to out_valid
  task automatic apply_one(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [TAG_W-1:0] tg, output logic [DATA_W-1:0] c,
                           output logic [TAG_W-1:0] t, output int lat);
    bus.a_in      = a;
    bus.b_in      = b;
    bus.tag_in    = tg;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    c = bus.c_out;
    t = bus.tag_out;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  vec_t vt[8];

  initial begin
    logic [DATA_W-1:0] c;
    logic [TAG_W-1:0]  t;
    int lat;
    int n0, m0;

    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.tag_in    = '0;
    bus.out_ready = 1'b0;

    for (longint x = 1; x < Q; x++)
      if ((x * R30) % Q == 1) inv30 = x;

    vt[0] = '{a: 14'd0,     b: 14'd5,     tag: 8'h2A, exp: 14'd0};
    vt[1] = '{a: 14'd1,     b: 14'd1,     tag: 8'h01, exp: model_c(1, 1)};
    vt[2] = '{a: 14'd12288, b: 14'd12288, tag: 8'h02, exp: model_c(12288, 12288)};
    vt[3] = '{a: 14'd12288, b: 14'd1,     tag: 8'h03, exp: model_c(12288, 1)};
    vt[4] = '{a: 14'd12288, b: 14'd0,     tag: 8'h04, exp: 14'd0};
    vt[5] = '{a: 14'd2,     b: 14'd3,     tag: 8'h05, exp: model_c(2, 3)};
    vt[6] = '{a: 14'd6144,  b: 14'd2,     tag: 8'hFE, exp: model_c(6144, 2)};
    vt[7] = '{a: 14'd5000,  b: 14'd7000,  tag: 8'h80, exp: model_c(5000, 7000)};

    // Held in reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_c_out", bus.c_out, 0);
    chk("rst_tag_out", bus.tag_out, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vector table, one item at a time
    foreach (vt[i]) begin
      apply_one(vt[i].a, vt[i].b, vt[i].tag, c, t, lat);
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_c", i), c, vt[i].exp);
      chk($sformatf("vec%0d_tag", i), t, vt[i].tag);
      chk($sformatf("vec%0d_rel", i),
          (longint'(c) * R30 + longint'(vt[i].a) * longint'(vt[i].b)) % Q, 0);
      chk($sformatf("vec%0d_not_q", i), longint'(c) < Q, 1);
      chk($sformatf("vec%0d_single_cycle", i), bus.out_valid, 0);
    end

    // Mid-flight reset: three items in, oldest parked in S4, then reset
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a_in     = 14'(i + 1);
      bus.b_in     = 14'(i + 7);
      bus.tag_in   = 8'(8'h10 + i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_out_valid", bus.out_valid, 1);
    rst = 1'b0;
    #2;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_c_out", bus.c_out, 0);
    chk("midrst_tag_out", bus.tag_out, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_stale", bus.out_valid, 0);
    end
    apply_one(14'd77, 14'd91, 8'h5C, c, t, lat);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_c", c, model_c(77, 91));
    chk("post_rst_tag", t, 8'h5C);

    // Full-rate stream: 1000 items through in 1003 edges
    n0 = n_out;
    m0 = n_in;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 1003; i++) begin
      bus.in_valid = (i < 1000);
      bus.a_in     = 14'($urandom_range(0, 12288));
      bus.b_in     = 14'($urandom_range(0, 12288));
      bus.tag_in   = 8'(i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk); #1;
    chk("stream_accepted", n_in - m0, 1000);
    chk("stream_results", n_out - n0, 1000);
    chk("stream_sb_empty", sb.size(), 0);

    // Random backpressure with a forced 6-cycle stall on a full pipeline
    n0 = n_out;
    m0 = n_in;
    for (int i = 0; i < 400; i++) begin
      if (i >= 196 && i < 200) begin
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
      end else if (i >= 200 && i < 206) begin
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
      end else begin
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      bus.a_in   = 14'($urandom_range(0, 12288));
      bus.b_in   = 14'($urandom_range(0, 12288));
      bus.tag_in = 8'(i);
      if (i == 205) begin
        chk("bp_full_out_valid", bus.out_valid, 1);
        chk("bp_full_in_ready", bus.in_ready, 0);
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    chk("bp_drained", sb.size(), 0);
    chk("bp_no_loss", n_out - n0, n_in - m0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
